imem_loader: RTL
================

# imem_loader

Hardware program loader for the MIPS core: the synthesizable counterpart of a bench that preloads instruction memory. It receives a byte stream over a valid/ready interface and assembles big-endian 32-bit instruction words. It writes them into instruction memory while holding the CPU, validates an XOR checksum, then releases the CPU with the PC cleared to 0. It sits between a host link (UART/debug bridge) and the instruction memory write port.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words.

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte; transfer when rx_valid && rx_ready
- load_req  in  1  single-cycle request to start a new load from RUN or ERR
- im_we  out  1  instruction-memory write strobe, one cycle per word
- im_addr  out  ADDR_W  word address of write (byte address = im_addr*4)
- im_wdata  out  32  instruction word, first received byte in [31:24]
- cpu_hold  out  1  CPU stalled/held while 1
- pc_clear  out  1  one-cycle pulse forcing PC to 0 at release
- done  out  1  load complete and checksum good
- error  out  1  load failed (oversize or checksum mismatch)
- words_loaded  out  ADDR_W+1  words written in current/last load

## Operation
- Frame: COUNT_HI, COUNT_LO (16-bit word count N), N*4 payload bytes, 1 checksum byte = XOR of all payload bytes. Header and checksum bytes are excluded from the XOR.
- States: HDR0 -> HDR1 -> DATA -> CSUM -> RUN | ERR.
- HDR0: accept byte into count[15:8]; clear xor accumulator, byte index, words_loaded, done, error.
- HDR1: accept byte into count[7:0].
  - N == 0 -> CSUM.
  - N > 2^ADDR_W -> ERR.
  - Otherwise -> DATA.
- DATA: each accepted byte is shifted into the word register (big-endian) and XORed into the accumulator.
  - On 4th byte: schedule write of word to address words_loaded, then words_loaded increments.
  - After word N-1 -> CSUM.
- CSUM: accept one byte.
  - Equal to accumulator -> RUN: cpu_hold=0, pc_clear pulse, done=1.
  - Else -> ERR: error=1, cpu_hold stays 1.
- RUN/ERR: rx_ready=0; bytes are not consumed. load_req -> HDR0, cpu_hold=1, done=0, error=0.
- load_req outside RUN/ERR is ignored.
- rx_ready = 1 in HDR0, HDR1, DATA, CSUM (decoded from state).
- Arithmetic: byte index 2 bits, wraps 3->0 per word; words_loaded saturates at N, never exceeds 2^ADDR_W.

## Timing
- Reset (rst_n=0, asynchronous): state HDR0. Outputs:
  - rx_ready=1, im_we=0, im_addr=0, im_wdata=0, cpu_hold=1.
  - pc_clear=0, done=0, error=0, words_loaded=0.
- Write latency: im_we, im_addr and im_wdata are registered and assert in the cycle after the 4th byte of a word is accepted, for exactly one cycle. They are stable for that whole cycle.
- rx_valid gaps are tolerated anywhere; state advances only on accepted bytes. No timeout.
- The last-word write strobe and CSUM byte acceptance may occur in the same cycle; both take effect.
- Release: cpu_hold falls and pc_clear pulses in the cycle after the checksum byte is accepted.
  - The final im_we precedes cpu_hold deassertion by at least 1 cycle.
  - done rises with cpu_hold falling.
- rst_n asserted mid-load: immediate abort to reset values; memory contents already written are left as-is. The next frame must restart from COUNT_HI.
- Single-cycle throughput: one byte per cycle sustained; a word every 4 cycles.

## Test plan
- Good load: COUNT 0x0003, payload 20 08 00 05 20 09 00 0A 01 09 50 20, checksum 0x76.
  - Three im_we pulses: addr 0/1/2 with 0x20080005, 0x2009000A, 0x01095020.
  - Then cpu_hold=0, one pc_clear pulse, done=1, words_loaded=3.
- Bad checksum: same frame, checksum 0x77.
  - Three writes still occur; then error=1, done=0, cpu_hold=1, no pc_clear, rx_ready=0.
- Zero/oversize: COUNT 0x0000 + checksum 0x00 -> done=1, no im_we.
  - With ADDR_W=8, COUNT 0x0101 -> error=1 right after COUNT_LO, no im_we.
  - COUNT 0x0100 accepted; last write at addr 255.
- Backpressure: good frame with rx_valid low 1-3 random cycles between bytes.
  - Writes identical to good load; each im_we exactly 1 cycle.
- Reset mid-load: assert rst_n=0 after 6 payload bytes.
  - All outputs at reset values asynchronously.
  - A fresh good frame then loads correctly from addr 0.
- Reload: after RUN, pulse load_req, then send COUNT 0x0001, 00 00 00 00, checksum 0x00.
  - cpu_hold=1 on the cycle after load_req; one write addr 0 data 0; done=1 again.

Source files
------------

// File: rtl/imem_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader_if : byte-stream input and instruction-memory write bus  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface imem_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  // host/memory side
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, im_we, im_addr, im_wdata
  );

  // loader side
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, im_we, im_addr, im_wdata
  );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader : framed byte-stream loader for instruction memory,      |
// | holds the CPU until an XOR-checked image is in place.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  imem_loader_if.slave       bus,
  input  wire logic          load_req,
  output logic               cpu_hold,
  output logic               pc_clear,
  output logic               done,
  output logic               error,
  output logic [ADDR_W:0]    words_loaded
);

  typedef enum logic [2:0] {
    S_HDR0 = 3'd0,
    S_HDR1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [16:0] c_cap = 17'd1 << ADDR_W;

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_count;
  logic [7:0]        r_xor;
  logic [1:0]        r_idx;
  logic [23:0]       r_word;
  logic [ADDR_W:0]   r_words;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_hold;
  logic              r_pc_clear;
  logic              r_done;
  logic              r_error;

  logic              w_accept;
  logic [15:0]       w_count;
  logic [ADDR_W:0]   w_words_inc;
  logic              w_last_word;

  assign bus.rx_ready = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                        (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_accept     = bus.rx_valid && bus.rx_ready;
  assign w_count      = {r_count[15:8], bus.rx_data};
  assign w_words_inc  = r_words + {{ADDR_W{1'b0}}, 1'b1};
  // word counter is zero-extended to the 16-bit frame count
  assign w_last_word  = ({{(15-ADDR_W){1'b0}}, w_words_inc} == r_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_HDR0;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR0: if (w_accept) w_next = S_HDR1;
      S_HDR1: begin
        if (w_accept) begin
          if (w_count == 16'd0)              w_next = S_CSUM;
          else if ({1'b0, w_count} > c_cap)  w_next = S_ERR;
          else                               w_next = S_DATA;
        end
      end
      S_DATA: if (w_accept && (r_idx == 2'd3) && w_last_word) w_next = S_CSUM;
      S_CSUM: if (w_accept) w_next = (bus.rx_data == r_xor) ? S_RUN : S_ERR;
      S_RUN,
      S_ERR:  if (load_req) w_next = S_HDR0;
      default: w_next = S_HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= 16'd0;
      r_xor      <= 8'd0;
      r_idx      <= 2'd0;
      r_word     <= 24'd0;
      r_words    <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_hold     <= 1'b1;
      r_pc_clear <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_we       <= 1'b0;
      r_pc_clear <= 1'b0;
      case (r_state)
        S_HDR0: begin
          if (w_accept) begin
            r_count[15:8] <= bus.rx_data;
            r_xor         <= 8'd0;
            r_idx         <= 2'd0;
            r_words       <= '0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
          end
        end
        S_HDR1: begin
          if (w_accept) begin
            r_count[7:0] <= bus.rx_data;
            if (w_next == S_ERR) r_error <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_xor <= r_xor ^ bus.rx_data;
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_we    <= 1'b1;
              r_addr  <= r_words[ADDR_W-1:0];
              r_wdata <= {r_word, bus.rx_data};
              r_words <= w_words_inc;
            end else begin
              r_word  <= {r_word[15:0], bus.rx_data};
            end
          end
        end
        S_CSUM: begin
          if (w_accept) begin
            if (bus.rx_data == r_xor) begin
              r_hold     <= 1'b0;
              r_pc_clear <= 1'b1;
              r_done     <= 1'b1;
            end else begin
              r_error    <= 1'b1;
            end
          end
        end
        S_RUN,
        S_ERR: begin
          if (load_req) begin
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.im_we     = r_we;
  assign bus.im_addr   = r_addr;
  assign bus.im_wdata  = r_wdata;
  assign cpu_hold      = r_hold;
  assign pc_clear      = r_pc_clear;
  assign done          = r_done;
  assign error         = r_error;
  assign words_loaded  = r_words;

endmodule
`default_nettype wire
